fetch_seq_ctrl: RTL and testbench
=================================

Name: fetch_seq_ctrl

Overview:
Fetch-stage sequencer for the single-issue RISC-V core. It owns the PC and drives the instruction-memory request/ack handshake. It holds one fetched instruction for decode under a valid/ready handshake. It resolves EX-stage branch/jump decisions using the core's 3-bit branch encoding and redirects the PC, flushing younger stages and discarding stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
CNT_W, 32, width of redirect performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  EX stage holds a valid instruction this cycle
branch  in  3  branch code: 0 NO, 1 JUMP_PC, 2 JUMP_REG, 4 EQ, 5 UEQ, 6 LT, 7 GE(~less); 3 treated as NO
less  in  1  ALU less-than flag
zero  in  1  ALU zero flag
ex_pc  in  32  PC of EX instruction
ex_imm  in  32  sign-extended immediate
ex_rs1  in  32  rs1 operand (JUMP_REG base)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid with imem_ack
if_valid  out  1  if_instr/if_pc valid to decode
if_instr  out  32  buffered instruction
if_pc  out  32  PC of buffered instruction
id_ready  in  1  decode accepts buffer this cycle
flush  out  1  combinational: clear IF/ID and ID/EX registers
misalign  out  1  sticky: redirect target not word aligned
redirect_cnt  out  CNT_W  number of redirects taken, wraps

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_instr=0, if_pc=0, misalign=0, redirect_cnt=0, halt_pending=0. Reset mid-handshake abandons the request; imem_req is 0 the next cycle.
- taken (combinational) = ex_valid & (branch==1 | branch==2 | (branch==4 & zero) | (branch==5 & ~zero) | (branch==6 & less) | (branch==7 & ~less)).
- target = (branch==2) ? ((ex_rs1+ex_imm) & ~32'h1) : (ex_pc+ex_imm); 32-bit, overflow wraps. bad = target[1].
- flush = taken, in the same cycle, in every state except HALT.
- imem_addr = pc. imem_req = 1 in REQ and DISCARD. Once asserted, imem_req and imem_addr stay stable until imem_ack.
- States:
  - IDLE: enter REQ the next cycle.
  - REQ: on imem_ack without taken, load if_instr=imem_rdata, if_pc=pc, if_valid=1, pc+=4, go to HOLD.
  - HOLD: if_valid=1, no request. When id_ready is high, clear if_valid and go to REQ, so one instruction issues per 2+ cycles.
  - DISCARD: keep the request to the drain address until imem_ack. Drop the data (if_valid stays 0). Then go to REQ, or to HALT if halt_pending.
  - HALT: all outputs idle except misalign and redirect_cnt. Exit only via rst.
- Redirect (taken) has priority over all other events in IDLE, REQ, HOLD, DISCARD:
  - pc<=target; if_valid<=0; redirect_cnt+=1.
  - In REQ: with imem_ack the same cycle, drop the data and go to REQ. Without ack, go to DISCARD; imem_addr stays at the old pc until ack, and the next REQ uses the target.
  - In HOLD or IDLE: go to REQ. id_ready the same cycle is ignored, because the buffer is flushed.
  - In DISCARD: pc<=new target and stay in DISCARD; the last redirect wins.
  - If bad: set misalign=1 and halt_pending=1. If no request is outstanding, go to HALT directly; otherwise go through DISCARD and then HALT. The counter still increments.
- taken and id_ready in HOLD together: redirect wins, and the buffered instruction counts as not consumed.
- ex_valid=0 means no redirect, regardless of branch.

Test Plan:
1. rst then release, imem_ack 1 cycle after each req, id_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc matches each; if_valid pulses every 2 cycles after the first.
2. Hold id_ready=0 for 5 cycles while in HOLD -> if_valid stays 1, if_instr/if_pc stable, imem_req=0; id_ready=1 -> next req at pc+4.
3. REQ at 0x10 with ack delayed 3 cycles; EQ with zero=1, ex_pc=0x8, ex_imm=0x20 -> flush=1 that cycle; ack data dropped; next imem_addr=0x28; redirect_cnt=1.
4. JUMP_REG ex_rs1=0x1001, ex_imm=0x4 -> target 0x1004, no misalign; JUMP_PC ex_pc=0x0, ex_imm=0x6 -> misalign=1, HALT after the outstanding ack, imem_req stays 0 afterwards.
5. LT with less=0, GE with less=1, UEQ with zero=1, branch=3, and ex_valid=0 with branch=1 -> no flush, sequential fetch continues, redirect_cnt unchanged.
6. Two redirects during DISCARD (targets 0x40 then 0x80) and rst asserted mid-REQ -> first case: the fetch after ack is at 0x80, cnt=2. Second case: the next cycle has imem_req=0, pc=RESET_PC, all outputs at reset values.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem req/ack handshake, buffers one instruction for decode.
// Latency: one instruction per 2+ cycles. Backpressure: id_ready low holds the buffer and stops fetching.
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [2:0]       branch,
    input  logic             less,
    input  logic             zero,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    input  logic             id_ready,
    output logic             flush,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      pc, pc_nxt;
    logic [31:0]      drain_addr, drain_addr_nxt;
    logic             if_valid_nxt;
    logic [31:0]      if_instr_nxt, if_pc_nxt;
    logic             misalign_nxt;
    logic             halt_pending, halt_pending_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             taken;
    logic             bad;
    logic [31:0]      target;

    always_comb begin
        taken = 1'b0;
        if (ex_valid) begin
            case (branch)
                3'd1, 3'd2: taken = 1'b1;
                3'd4:       taken = zero;
                3'd5:       taken = ~zero;
                3'd6:       taken = less;
                3'd7:       taken = ~less;
                default:    taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        target = ex_pc + ex_imm;
        if (branch == 3'd2) begin
            target = (ex_rs1 + ex_imm) & ~32'h1;
        end
    end

    assign bad          = target[1];
    assign flush        = taken && (state != S_HALT);
    assign imem_req     = (state == S_REQ) || (state == S_DISCARD);
    // While draining a stale fetch the request address must not move, even though pc already points at the redirect target.
    assign imem_addr    = (state == S_DISCARD) ? drain_addr : pc;

    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        drain_addr_nxt   = drain_addr;
        if_valid_nxt     = if_valid;
        if_instr_nxt     = if_instr;
        if_pc_nxt        = if_pc;
        misalign_nxt     = misalign;
        halt_pending_nxt = halt_pending;
        cnt_nxt          = redirect_cnt;

        if (flush) begin
            pc_nxt       = target;
            if_valid_nxt = 1'b0;
            cnt_nxt      = redirect_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (bad) begin
                misalign_nxt     = 1'b1;
                halt_pending_nxt = 1'b1;
            end
            if (imem_req && !imem_ack) begin
                state_nxt = S_DISCARD;
                if (state == S_REQ) begin
                    drain_addr_nxt = pc;
                end
            end else begin
                state_nxt = (halt_pending || bad) ? S_HALT : S_REQ;
            end
        end else begin
            case (state)
                S_IDLE: state_nxt = S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        if_valid_nxt = 1'b1;
                        if_instr_nxt = imem_rdata;
                        if_pc_nxt    = pc;
                        pc_nxt       = pc + 32'd4;
                        state_nxt    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        if_valid_nxt = 1'b0;
                        state_nxt    = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        state_nxt = halt_pending ? S_HALT : S_REQ;
                    end
                end
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            drain_addr   <= RESET_PC;
            if_valid     <= 1'b0;
            if_instr     <= 32'h0;
            if_pc        <= 32'h0;
            misalign     <= 1'b0;
            halt_pending <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            drain_addr   <= drain_addr_nxt;
            if_valid     <= if_valid_nxt;
            if_instr     <= if_instr_nxt;
            if_pc        <= if_pc_nxt;
            misalign     <= misalign_nxt;
            halt_pending <= halt_pending_nxt;
            redirect_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_seq_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  branch;
    logic        less, zero;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        id_ready;
    logic        flush;
    logic        misalign;
    logic [31:0] redirect_cnt;

    int errors = 0;
    int checks = 0;

    fetch_seq_ctrl #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .branch(branch), .less(less), .zero(zero),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .id_ready(id_ready), .flush(flush), .misalign(misalign),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model state: a pending fetch, whether it is stale, and the decode buffer.
    bit          m_started, m_out, m_drop, m_buf, m_halt, m_hp, m_mis;
    logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_cnt;

    task automatic idle_inputs();
        ex_valid = 0; branch = 0; less = 0; zero = 0;
        ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
        imem_ack = 0; imem_rdata = 0; id_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        repeat (3) @(negedge clk);
        rst = 0;
    endtask

    task automatic wait_req(input int limit, output bit got);
        got = 0;
        for (int i = 0; i < limit; i++) begin
            if (imem_req === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic bit ref_taken(bit v, logic [2:0] b, bit l, bit z);
        if (!v) return 1'b0;
        case (b)
            3'd1, 3'd2: return 1'b1;
            3'd4:       return z;
            3'd5:       return !z;
            3'd6:       return l;
            3'd7:       return !l;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(logic [2:0] b, logic [31:0] pc, logic [31:0] imm, logic [31:0] rs1);
        if (b == 3'd2) return (rs1 + imm) & 32'hFFFF_FFFE;
        return pc + imm;
    endfunction

    task automatic model_step();
        bit          tk;
        logic [31:0] tgt;
        tk  = ref_taken(ex_valid, branch, less, zero);
        tgt = ref_target(branch, ex_pc, ex_imm, ex_rs1);
        if (m_halt) return;
        if (tk) begin
            m_cnt = m_cnt + 1; m_pc = tgt; m_buf = 0; m_started = 1;
            if (tgt[1]) begin m_mis = 1; m_hp = 1; end
            if (m_out && !imem_ack) m_drop = 1;
            else if (m_hp) begin m_halt = 1; m_out = 0; end
            else begin m_out = 1; m_drop = 0; m_addr = tgt; end
        end else if (!m_started) begin
            m_started = 1; m_out = 1; m_drop = 0; m_addr = m_pc;
        end else if (m_out && imem_ack) begin
            if (m_drop) begin
                m_drop = 0;
                if (m_hp) begin m_halt = 1; m_out = 0; end
                else m_addr = m_pc;
            end else begin
                m_buf = 1; m_instr = imem_rdata; m_ipc = m_addr; m_pc = m_pc + 4; m_out = 0;
            end
        end else if (m_buf && id_ready) begin
            m_buf = 0; m_out = 1; m_addr = m_pc;
        end
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        ex_valid = 1; branch = 3'd1; ex_imm = 32'h40;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        checks++; if (redirect_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", redirect_cnt); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
        idle_inputs();
        rst = 0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL first_req: req %b addr %h want 1 %h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        bit got;
        id_ready = 1;
        for (int k = 0; k < 3; k++) begin
            wait_req(10, got);
            checks++; if (!got || imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr%0d: got req %b addr %h want %h", k, got, imem_addr, 32'(4 * k)); end
            imem_ack = 1; imem_rdata = 32'h1000_0000 + 32'(k);
            @(negedge clk);
            imem_ack = 0;
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin errors++; $display("FAIL seq_hold%0d: valid %b pc %h want 1 %h", k, if_valid, if_pc, 32'(4 * k)); end
            checks++; if (if_instr !== 32'h1000_0000 + 32'(k) || imem_req !== 1'b0) begin errors++; $display("FAIL seq_instr%0d: instr %h req %b", k, if_instr, imem_req); end
            @(negedge clk);
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_pulse%0d: valid %b want 0", k, if_valid); end
        end
    endtask

    task automatic test_stall();
        id_ready = 0;
        imem_ack = 1; imem_rdata = 32'hCAFE_000C;
        @(negedge clk);
        imem_ack = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'hCAFE_000C || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall%0d: valid %b pc %h instr %h req %b", i, if_valid, if_pc, if_instr, imem_req); end
            @(negedge clk);
        end
        id_ready = 1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL stall_resume: req %b addr %h want 1 10", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_req();
        ex_valid = 1; branch = 3'd4; zero = 1; ex_pc = 32'h8; ex_imm = 32'h20;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL redir_flush: got %b want 1", flush); end
        @(negedge clk);
        idle_inputs(); id_ready = 1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL redir_drain: req %b addr %h want 1 10", imem_req, imem_addr); end
        checks++; if (redirect_cnt !== 32'd1) begin errors++; $display("FAIL redir_cnt: got %0d want 1", redirect_cnt); end
        @(negedge clk);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_drop: valid %b want 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h28) begin errors++; $display("FAIL redir_target: req %b addr %h want 1 28", imem_req, imem_addr); end
    endtask

    task automatic test_not_taken();
        logic [5:0] pat [5];
        pat[0] = {1'b1, 3'd6, 1'b0, 1'b0};
        pat[1] = {1'b1, 3'd7, 1'b1, 1'b0};
        pat[2] = {1'b1, 3'd5, 1'b0, 1'b1};
        pat[3] = {1'b1, 3'd3, 1'b1, 1'b1};
        pat[4] = {1'b0, 3'd1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            {ex_valid, branch, less, zero} = pat[i];
            ex_pc = 32'h100; ex_imm = 32'h40; ex_rs1 = 32'h200;
            #1;
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nt_flush%0d: got %b want 0", i, flush); end
            @(negedge clk);
        end
        idle_inputs(); id_ready = 1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h28 || redirect_cnt !== 32'd1) begin
            errors++; $display("FAIL nt_state: req %b addr %h cnt %0d want 1 28 1", imem_req, imem_addr, redirect_cnt); end
        imem_ack = 1; imem_rdata = 32'h0000_0028;
        @(negedge clk);
        imem_ack = 0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h28) begin errors++; $display("FAIL nt_hold: valid %b pc %h want 1 28", if_valid, if_pc); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2C) begin errors++; $display("FAIL nt_next: req %b addr %h want 1 2c", imem_req, imem_addr); end
    endtask

    task automatic test_jump_misalign();
        ex_valid = 1; branch = 3'd2; ex_rs1 = 32'h1001; ex_imm = 32'h4;
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jr_flush: got %b want 1", flush); end
        @(negedge clk);
        idle_inputs();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1004 || if_valid !== 1'b0) begin
            errors++; $display("FAIL jr_target: req %b addr %h valid %b want 1 1004 0", imem_req, imem_addr, if_valid); end
        checks++; if (misalign !== 1'b0 || redirect_cnt !== 32'd2) begin errors++; $display("FAIL jr_status: mis %b cnt %0d want 0 2", misalign, redirect_cnt); end
        ex_valid = 1; branch = 3'd1; ex_pc = 32'h0; ex_imm = 32'h6;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jpc_flush: got %b want 1", flush); end
        @(negedge clk);
        idle_inputs();
        checks++; if (misalign !== 1'b1 || redirect_cnt !== 32'd3) begin errors++; $display("FAIL jpc_status: mis %b cnt %0d want 1 3", misalign, redirect_cnt); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1004) begin errors++; $display("FAIL jpc_drain: req %b addr %h want 1 1004", imem_req, imem_addr); end
        imem_ack = 1;
        @(negedge clk);
        imem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1; branch = 3'd1; ex_imm = 32'h100; id_ready = 1;
            #1;
            checks++; if (flush !== 1'b0 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
                errors++; $display("FAIL halt%0d: flush %b req %b valid %b want 0 0 0", i, flush, imem_req, if_valid); end
            @(negedge clk);
            checks++; if (redirect_cnt !== 32'd3 || misalign !== 1'b1) begin errors++; $display("FAIL halt_cnt%0d: cnt %0d mis %b want 3 1", i, redirect_cnt, misalign); end
        end
        idle_inputs();
    endtask

    task automatic test_discard_double();
        do_reset();
        @(negedge clk);
        ex_valid = 1; branch = 3'd1; ex_pc = 32'h0; ex_imm = 32'h40;
        @(negedge clk);
        ex_imm = 32'h80;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL dd_flush2: got %b want 1", flush); end
        @(negedge clk);
        idle_inputs();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL dd_drain: req %b addr %h want 1 0", imem_req, imem_addr); end
        imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || if_valid !== 1'b0) begin
            errors++; $display("FAIL dd_target: req %b addr %h valid %b want 1 80 0", imem_req, imem_addr, if_valid); end
        checks++; if (redirect_cnt !== 32'd2) begin errors++; $display("FAIL dd_cnt: got %0d want 2", redirect_cnt); end
    endtask

    task automatic test_reset_mid_req();
        imem_ack = 1; imem_rdata = 32'h55AA_55AA;
        @(negedge clk);
        imem_ack = 0;
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'h55AA_55AA) begin errors++; $display("FAIL rm_fill: valid %b instr %h", if_valid, if_instr); end
        id_ready = 1;
        @(negedge clk);
        id_ready = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h84) begin errors++; $display("FAIL rm_req: req %b addr %h want 1 84", imem_req, imem_addr); end
        rst = 1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin errors++; $display("FAIL rm_req0: req %b addr %h want 0 %h", imem_req, imem_addr, RESET_PC); end
        checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL rm_buf: valid %b instr %h pc %h want 0", if_valid, if_instr, if_pc); end
        checks++; if (redirect_cnt !== 32'h0 || misalign !== 1'b0) begin errors++; $display("FAIL rm_status: cnt %0d mis %b want 0 0", redirect_cnt, misalign); end
        rst = 0;
    endtask

    task automatic test_random();
        bit exp_flush;
        do_reset();
        m_started = 0; m_out = 0; m_drop = 0; m_buf = 0; m_halt = 0; m_hp = 0; m_mis = 0;
        m_pc = RESET_PC; m_addr = RESET_PC; m_instr = 0; m_ipc = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (imem_req !== m_out) begin errors++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, imem_req, m_out); end
            if (m_out) begin
                checks++; if (imem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, imem_addr, m_addr); end
            end
            checks++; if (if_valid !== m_buf) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, if_valid, m_buf); end
            if (m_buf) begin
                checks++; if (if_instr !== m_instr || if_pc !== m_ipc) begin errors++; $display("FAIL rnd_buf@%0d: instr %h pc %h want %h %h", cyc, if_instr, if_pc, m_instr, m_ipc); end
            end
            checks++; if (redirect_cnt !== m_cnt || misalign !== m_mis) begin errors++; $display("FAIL rnd_status@%0d: cnt %0d mis %b want %0d %b", cyc, redirect_cnt, misalign, m_cnt, m_mis); end

            ex_valid = ($urandom_range(0, 3) == 0);
            branch   = 3'($urandom_range(0, 7));
            less     = 1'($urandom_range(0, 1));
            zero     = 1'($urandom_range(0, 1));
            ex_pc    = $urandom & 32'hFFFF_FFFC;
            ex_imm   = $urandom & 32'hFFFF_FFFC;
            ex_rs1   = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            imem_ack = (imem_req === 1'b1) && ($urandom_range(0, 4) < 2);
            imem_rdata = $urandom;
            id_ready = 1'($urandom_range(0, 1));
            #1;
            exp_flush = ref_taken(ex_valid, branch, less, zero) && !m_halt;
            checks++; if (flush !== exp_flush) begin errors++; $display("FAIL rnd_flush@%0d: got %b want %b", cyc, flush, exp_flush); end
            model_step();
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_req();
        test_not_taken();
        test_jump_misalign();
        test_discard_double();
        test_reset_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
